// File: rtl/fetch_queue_if.sv
// Fetch2 -> fetch_queue -> decode signal bundle.
// master drives the fetch pair plus flush/ready; slave is the queue itself.
interface fetch_queue_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] inst0_i;
   logic [XLEN-1:0] inst1_i;
   logic            valid0_i;
   logic            valid1_i;
   logic [XLEN-1:0] pc_i;
   logic            pred_0_i;
   logic            pred_1_i;
   logic            flush_i;
   logic            ready_i;
   logic            full_o;
   logic [XLEN-1:0] inst0_o;
   logic [XLEN-1:0] inst1_o;
   logic [XLEN-1:0] pc0_o;
   logic [XLEN-1:0] pc1_o;
   logic            pred0_o;
   logic            pred1_o;
   logic            out0_valid_o;
   logic            out1_valid_o;

   modport master (
      output inst0_i, inst1_i, valid0_i, valid1_i, pc_i, pred_0_i, pred_1_i,
             flush_i, ready_i,
      input  full_o, inst0_o, inst1_o, pc0_o, pc1_o, pred0_o, pred1_o,
             out0_valid_o, out1_valid_o
   );

   modport slave (
      input  inst0_i, inst1_i, valid0_i, valid1_i, pc_i, pred_0_i, pred_1_i,
             flush_i, ready_i,
      output full_o, inst0_o, inst1_o, pc0_o, pc1_o, pred0_o, pred1_o,
             out0_valid_o, out1_valid_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Dual-slot compacting instruction queue between fetch2 and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: live slots pass straight through an empty queue.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input logic          clock_i,
   input logic          reset_n_i,
   fetch_queue_if.slave fq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(DEPTH - 2);

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            pred;
   } entry_t;

   entry_t mem [DEPTH];

   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [PTR_W-1:0] head_plus1, tail_plus1;
   logic [CNT_W-1:0] live_n, enq_n, deq_n;
   entry_t           slot0, slot1, wr_a, rd0, rd1;
   logic             both_live, any_live, full, stored0, stored1;
   logic             enq_en, write_en, v0_out, v1_out;

   always_comb begin
      slot0      = '{inst: fq.inst0_i, pc: fq.pc_i, pred: fq.pred_0_i};
      slot1      = '{inst: fq.inst1_i, pc: fq.pc_i + XLEN'(4), pred: fq.pred_1_i};
      both_live  = fq.valid0_i & fq.valid1_i;
      any_live   = fq.valid0_i | fq.valid1_i;
      // Compaction: the older live slot always lands at tail.
      wr_a       = fq.valid0_i ? slot0 : slot1;
      live_n     = CNT_W'(fq.valid0_i) + CNT_W'(fq.valid1_i);
      head_plus1 = head_reg + PTR_W'(1);
      tail_plus1 = tail_reg + PTR_W'(1);

      full       = count_reg > FULL_LIM;
      stored0    = count_reg != '0;
      stored1    = count_reg > CNT_W'(1);
      enq_en     = !full && !fq.flush_i;
      deq_n      = fq.ready_i ? (CNT_W'(stored0) + CNT_W'(stored1)) : '0;

      rd0        = stored0 ? mem[head_reg]   : '0;
      rd1        = stored1 ? mem[head_plus1] : '0;
      v0_out     = stored0;
      v1_out     = stored1;
      write_en   = enq_en;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (reset_n_i && count_reg == '0 && !fq.flush_i && any_live) begin
         rd0    = wr_a;
         rd1    = both_live ? slot1 : '0;
         v0_out = 1'b1;
         v1_out = both_live;
         // Decode took them this cycle, so they never enter storage.
         if (fq.ready_i) begin
            write_en = 1'b0;
         end
      end
`endif
      enq_n      = write_en ? live_n : '0;
      count_next = count_reg + enq_n - deq_n;
   end

   assign fq.full_o       = full;
   assign fq.out0_valid_o = v0_out;
   assign fq.out1_valid_o = v1_out;
   assign fq.inst0_o      = rd0.inst;
   assign fq.inst1_o      = rd1.inst;
   assign fq.pc0_o        = rd0.pc;
   assign fq.pc1_o        = rd1.pc;
   assign fq.pred0_o      = rd0.pred;
   assign fq.pred1_o      = rd1.pred;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (fq.flush_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_reg + deq_n[PTR_W-1:0];
         tail_reg  <= tail_reg + enq_n[PTR_W-1:0];
         count_reg <= count_next;
      end
   end

   // Storage carries no reset; entry validity comes solely from count_reg.
   always_ff @(posedge clock_i) begin
      if (write_en && any_live) begin
         mem[tail_reg] <= wr_a;
      end
      if (write_en && both_live) begin
         mem[tail_plus1] <= slot1;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
// Honours FETCH_QUEUE_BYPASS_EN when the build defines it.
module tb_fetch_queue;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            pred;
   } entry_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   entry_t model_q[$];

   fetch_queue_if #(.XLEN(XLEN)) fq ();

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .fq        (fq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_full"}, 32'(fq.full_o), 32'd0);
      check({tag, "_v0"},   32'(fq.out0_valid_o), 32'd0);
      check({tag, "_v1"},   32'(fq.out1_valid_o), 32'd0);
      check({tag, "_i0"},   fq.inst0_o, 32'd0);
      check({tag, "_i1"},   fq.inst1_o, 32'd0);
      check({tag, "_pc0"},  fq.pc0_o, 32'd0);
      check({tag, "_pc1"},  fq.pc1_o, 32'd0);
      check({tag, "_pr"},   32'({fq.pred0_o, fq.pred1_o}), 32'd0);
   endtask

   // One clock of traffic: drive at negedge, compare outputs to the model, then advance the model.
   task automatic step(input logic v0, input logic v1,
                       input logic [XLEN-1:0] i0, input logic [XLEN-1:0] i1,
                       input logic [XLEN-1:0] pc, input logic p0, input logic p1,
                       input logic fl, input logic rdy);
      entry_t live[$];
      entry_t e0, e1;
      logic   ev0, ev1, was_full, bypassed;
      int     sz, npop;
      @(negedge clk);
      fq.inst0_i  = i0;   fq.inst1_i  = i1;
      fq.valid0_i = v0;   fq.valid1_i = v1;
      fq.pc_i     = pc;
      fq.pred_0_i = p0;   fq.pred_1_i = p1;
      fq.flush_i  = fl;   fq.ready_i  = rdy;
      if (v0) live.push_back('{inst: i0, pc: pc, pred: p0});
      if (v1) live.push_back('{inst: i1, pc: pc + 32'd4, pred: p1});
      sz  = model_q.size();
      ev0 = sz >= 1;
      ev1 = sz >= 2;
      e0  = '0;
      e1  = '0;
      if (ev0) e0 = model_q[0];
      if (ev1) e1 = model_q[1];
`ifdef FETCH_QUEUE_BYPASS_EN
      if (sz == 0 && !fl && live.size() > 0) begin
         ev0 = 1'b1;
         e0  = live[0];
         ev1 = live.size() == 2;
         if (ev1) e1 = live[1];
      end
`endif
      #1;
      check("full", 32'(fq.full_o), 32'(sz > DEPTH - 2));
      check("v0",   32'(fq.out0_valid_o), 32'(ev0));
      check("v1",   32'(fq.out1_valid_o), 32'(ev1));
      check("inst0", fq.inst0_o, e0.inst);
      check("pc0",   fq.pc0_o,   e0.pc);
      check("pred0", 32'(fq.pred0_o), 32'(e0.pred));
      check("inst1", fq.inst1_o, e1.inst);
      check("pc1",   fq.pc1_o,   e1.pc);
      check("pred1", 32'(fq.pred1_o), 32'(e1.pred));
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else begin
         was_full = sz > DEPTH - 2;
         npop     = rdy ? ((sz >= 2) ? 2 : sz) : 0;
         repeat (npop) void'(model_q.pop_front());
         bypassed = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
         bypassed = (sz == 0) && rdy && (live.size() > 0);
`endif
         if (!was_full && !bypassed) begin
            foreach (live[k]) model_q.push_back(live[k]);
         end
      end
      $display("cyc %0d v=%b%b pc=%h fl=%b rdy=%b occ=%0d", cyc, v0, v1, pc, fl, rdy, model_q.size());
      cyc++;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic push1(input logic [XLEN-1:0] pc);
      step(1'b1, 1'b0, pc ^ 32'hA5A5_0000, 32'h0, pc, pc[3], 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push2(input logic [XLEN-1:0] pc, input logic rdy);
      step(1'b1, 1'b1, pc ^ 32'h1111_0000, pc ^ 32'h2222_0000, pc, 1'b0, 1'b1, 1'b0, rdy);
   endtask

   initial begin
      fq.inst0_i = '0; fq.inst1_i = '0; fq.valid0_i = 1'b0; fq.valid1_i = 1'b0;
      fq.pc_i = '0; fq.pred_0_i = 1'b0; fq.pred_1_i = 1'b0;
      fq.flush_i = 1'b0; fq.ready_i = 1'b0;

      // Power-on reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_all_zero("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill past the full threshold, then drain in order.
      push2(32'h100, 1'b0);
      push2(32'h108, 1'b0);
      push2(32'h110, 1'b0);
      push2(32'h118, 1'b0);
      push2(32'h120, 1'b0);
      repeat (5) idle(1'b1);

      // Lone slot-1 instruction keeps its +4 PC.
      step(1'b0, 1'b1, 32'h0, 32'hBEEF, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Wrap: head reaches DEPTH-1 with three entries, then enqueue-2 + dequeue-2.
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) push1(32'h300 + 32'(k * 8));
      repeat (3) idle(1'b1);
      push2(32'h400, 1'b1);
      push1(32'h408);
      push2(32'h410, 1'b1);
      repeat (3) idle(1'b1);

      // Flush beats a same-cycle pair and ready.
      push2(32'h500, 1'b0);
      step(1'b1, 1'b1, 32'h51, 32'h52, 32'h510, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(1'b1);

      // Empty queue, valid pair with ready: bypass or one-cycle latency.
      step(1'b1, 1'b1, 32'hA, 32'hB, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset with five entries in flight.
      push2(32'h700, 1'b0);
      push2(32'h708, 1'b0);
      push1(32'h710);
      @(negedge clk);
      fq.valid0_i = 1'b0; fq.valid1_i = 1'b0; fq.ready_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("arst");
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
              1'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 9) < 6));
      end
      repeat (5) idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
